mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port SRAM256x16. It shares the memory between the processor core (fetch/load/store traffic from cu) and a host port (program loader / debug / DMA). The block sits between both requesters and the SRAM pins and owns CSB1/WEB1/A1/I1. CPU has fixed priority with a starvation guard that guarantees the host a slot after a bounded CPU streak.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM256x16 port between the CPU and a host port.
// The CPU has fixed priority; a streak counter forces a host slot after
// MAX_CPU_BURST consecutive CPU grants made while the host was waiting.
// Every access is an IDLE -> ACCESS pair, so at most one access per two cycles.
module mem_arbiter #(
    parameter int MAX_CPU_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [0:7]  cpu_addr,
    input  logic [0:15] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [0:15] cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [0:7]  host_addr,
    input  logic [0:15] host_wdata,
    output logic        host_ack,
    output logic        host_rvalid,
    output logic [0:15] host_rdata,
    output logic [0:7]  sram_addr,
    output logic        sram_csb,
    output logic        sram_web,
    output logic [0:15] sram_wdata,
    input  logic [0:15] sram_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_CPU_BURST);

    state_t     state;
    logic       we_latched;
    logic [3:0] streak;
    logic       host_wins;

    // The host wins when it is the only requester, or when the CPU has
    // used up its allowed streak while the host was waiting.
    always_comb begin
        host_wins = host_req && (!cpu_req || (streak == BURST_LIMIT));
    end

    // Arbitration FSM: every SRAM pin, strobe and the streak counter are
    // registered here so the SRAM sees clean, glitch-free controls.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            we_latched  <= 1'b0;
            streak      <= 4'd0;
            owner       <= 1'b0;
            cpu_ack     <= 1'b0;
            host_ack    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            sram_csb    <= 1'b1;
            sram_web    <= 1'b1;
            sram_addr   <= '0;
            sram_wdata  <= '0;
        end else begin
            cpu_ack     <= 1'b0;
            host_ack    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || host_req) begin
                        state    <= ACCESS;
                        owner    <= host_wins;
                        sram_csb <= 1'b0;
                        if (host_wins) begin
                            we_latched <= host_we;
                            sram_web   <= !host_we;
                            sram_addr  <= host_addr;
                            sram_wdata <= host_wdata;
                            host_ack   <= 1'b1;
                        end else begin
                            we_latched <= cpu_we;
                            sram_web   <= !cpu_we;
                            sram_addr  <= cpu_addr;
                            sram_wdata <= cpu_wdata;
                            cpu_ack    <= 1'b1;
                        end
                    end
                    // A host grant or an idle cycle without a waiting host
                    // ends the streak; CPU grants over a waiting host extend it.
                    if (host_wins || !host_req) begin
                        streak <= 4'd0;
                    end else if (cpu_req && (streak < BURST_LIMIT)) begin
                        streak <= streak + 4'd1;
                    end
                end
                ACCESS: begin
                    state    <= IDLE;
                    sram_csb <= 1'b1;
                    sram_web <= 1'b1;
                    if (!we_latched) begin
                        cpu_rvalid  <= !owner;
                        host_rvalid <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == ACCESS);
    assign cpu_rdata  = sram_rdata;
    assign host_rdata = sram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a
// behavioural SRAM256x16 model attached to the sram_* pins.
module tb_mem_arbiter;

    localparam int CA = 0;
    localparam int HA = 1;
    localparam int CR = 2;
    localparam int HR = 3;

    localparam int S_CSB    = 0;
    localparam int S_WEB    = 1;
    localparam int S_BUSY   = 2;
    localparam int S_ADDR   = 3;
    localparam int S_WDATA  = 4;
    localparam int S_OWNER  = 5;
    localparam int S_STREAK = 6;
    localparam int S_STROBE = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [0:7]  cpu_addr, host_addr, sram_addr;
    logic [0:15] cpu_wdata, host_wdata, cpu_rdata, host_rdata;
    logic [0:15] sram_wdata, sram_rdata;
    logic        cpu_ack, cpu_rvalid, host_ack, host_rvalid;
    logic        sram_csb, sram_web, owner, busy;

    logic [0:15] mem [0:255];

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
    } lvl_t;

    ev_t  evQ[$];
    lvl_t lvlQ[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    string kindName [4] = '{"cpu_ack", "host_ack", "cpu_rvalid", "host_rvalid"};
    string sigName  [8] = '{"sram_csb", "sram_web", "busy", "sram_addr",
                            "sram_wdata", "owner", "streak", "strobe_count"};

    mem_arbiter #(.MAX_CPU_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clock = !clock;

    // Cycle counter used to time-stamp expected and observed events.
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural synchronous SRAM: operation happens at the edge ending ACCESS.
    always @(posedge clock) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_addr] <= sram_wdata;
            else           sram_rdata     <= mem[sram_addr];
        end
    end

    function automatic logic [15:0] getSig(input int s);
        case (s)
            S_CSB:    return {15'd0, sram_csb};
            S_WEB:    return {15'd0, sram_web};
            S_BUSY:   return {15'd0, busy};
            S_ADDR:   return {8'd0, sram_addr};
            S_WDATA:  return sram_wdata;
            S_OWNER:  return {15'd0, owner};
            S_STREAK: return {12'd0, dut.streak};
            default:  return 16'(int'(cpu_ack) + int'(host_ack) +
                                 int'(cpu_rvalid) + int'(host_rvalid));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe and
    // checks every scheduled level sample, away from the active edge.
    always @(negedge clock) begin
        int nStrobe;
        int obsKind;
        ev_t e;
        lvl_t l;
        nStrobe = int'(cpu_ack) + int'(host_ack) + int'(cpu_rvalid) + int'(host_rvalid);
        obsKind = cpu_ack ? CA : host_ack ? HA : cpu_rvalid ? CR : HR;
        if (nStrobe > 1) begin
            checkOutput("multiple_strobes", 16'(nStrobe), 16'd1);
        end else if (nStrobe == 1) begin
            if (evQ.size() == 0) begin
                checkOutput({"unexpected_", kindName[obsKind]}, 16'd1, 16'd0);
            end else begin
                e = evQ.pop_front();
                checkOutput({"kind_", kindName[e.kind]}, 16'(obsKind), 16'(e.kind));
                checkOutput({"cycle_", kindName[e.kind]}, 16'(cyc), 16'(e.cyc));
                if (e.kind == CR) checkOutput("cpu_rdata", cpu_rdata, e.data);
                if (e.kind == HR) checkOutput("host_rdata", host_rdata, e.data);
            end
        end
        while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
            e = evQ.pop_front();
            checkOutput({"missing_", kindName[e.kind]}, 16'(cyc), 16'(e.cyc));
        end
        while (lvlQ.size() > 0 && lvlQ[0].cyc <= cyc) begin
            l = lvlQ.pop_front();
            if (l.cyc == cyc) checkOutput(sigName[l.sig], getSig(l.sig), l.val);
            else              checkOutput({"late_", sigName[l.sig]}, 16'(cyc), 16'(l.cyc));
        end
    end

    task automatic expEv(input int kind, input int c, input logic [15:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        evQ.push_back(e);
    endtask

    task automatic expLvl(input int c, input int s, input logic [15:0] v);
        lvl_t l;
        l.cyc = c;
        l.sig = s;
        l.val = v;
        lvlQ.push_back(l);
    endtask

    task automatic tickN(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic isHost, input logic req, input logic we,
                                 input logic [7:0] a, input logic [15:0] d);
        if (isHost) begin
            host_req = req; host_we = we; host_addr = a; host_wdata = d;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    initial begin
        int t;
        logic [7:0]  rdAddr [18];
        logic [15:0] rdData [18];
        for (int i = 0; i < 16; i++) begin
            rdAddr[i] = 8'(i);
            rdData[i] = 16'(i + 1);
        end
        rdAddr[16] = 8'h50; rdData[16] = 16'h5555;
        rdAddr[17] = 8'h60; rdData[17] = 16'hAAAA;

        // Reset with both requests high: nothing may be granted.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 16'h2222);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 16'h4444);
        tickN(1);
        t = cyc;
        for (int c = t; c < t + 2; c++) begin
            expLvl(c, S_CSB, 16'd1);
            expLvl(c, S_WEB, 16'd1);
            expLvl(c, S_BUSY, 16'd0);
            expLvl(c, S_STROBE, 16'd0);
        end
        expLvl(t + 2, S_ADDR, 16'd0);
        expLvl(t + 2, S_WDATA, 16'd0);
        expLvl(t + 2, S_OWNER, 16'd0);
        expLvl(t + 2, S_STREAK, 16'd0);
        expLvl(t + 2, S_CSB, 16'd1);
        tickN(2);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);

        // CPU write 0xBEEF to 0x3C, then read it back.
        t = cyc;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, 16'hBEEF);
        expEv(CA, t + 1, 16'h0);
        expLvl(t + 1, S_CSB, 16'd0);
        expLvl(t + 1, S_WEB, 16'd0);
        expLvl(t + 1, S_ADDR, 16'h3C);
        expLvl(t + 1, S_WDATA, 16'hBEEF);
        expLvl(t + 1, S_BUSY, 16'd1);
        expLvl(t + 1, S_OWNER, 16'd0);
        tickN(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 16'h0000);
        expEv(CA, t + 3, 16'h0);
        expEv(CR, t + 4, 16'hBEEF);
        expLvl(t + 3, S_CSB, 16'd0);
        expLvl(t + 3, S_WEB, 16'd1);
        tickN(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        expLvl(t + 4, S_CSB, 16'd1);
        expLvl(t + 4, S_BUSY, 16'd0);
        tickN(2);

        // Simultaneous requests: CPU first, host two cycles later.
        t = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h50, 16'h5555);
        expEv(CA, t + 1, 16'h0);
        expEv(CR, t + 2, 16'hBEEF);
        expEv(HA, t + 3, 16'h0);
        expLvl(t + 1, S_OWNER, 16'd0);
        expLvl(t + 3, S_OWNER, 16'd1);
        expLvl(t + 3, S_ADDR, 16'h50);
        expLvl(t + 3, S_WEB, 16'd0);
        tickN(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);

        // Starvation guard: four CPU grants, then the host, then CPU again.
        t = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h60, 16'hAAAA);
        for (int i = 0; i < 4; i++) begin
            expEv(CA, t + 1 + 2 * i, 16'h0);
            expEv(CR, t + 2 + 2 * i, 16'hBEEF);
        end
        expEv(HA, t + 9, 16'h0);
        expEv(CA, t + 11, 16'h0);
        expEv(CR, t + 12, 16'hBEEF);
        expLvl(t + 8, S_STREAK, 16'd4);
        expLvl(t + 9, S_STREAK, 16'd0);
        expLvl(t + 9, S_OWNER, 16'd1);
        expLvl(t + 11, S_OWNER, 16'd0);
        expLvl(t + 12, S_STREAK, 16'd0);
        tickN(10);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);

        // Host loads 16 words with the CPU idle; busy toggles every cycle.
        t = cyc;
        for (int k = 0; k < 32; k++) expLvl(t + k, S_BUSY, 16'(k % 2));
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 8'(i), 16'(i + 1));
            expEv(HA, t + 2 * i + 1, 16'h0);
            tickN(2);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);

        // CPU reads back the loaded words plus the two host-written cells.
        t = cyc;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, rdAddr[i], 16'h0000);
            expEv(CA, t + 2 * i + 1, 16'h0);
            expEv(CR, t + 2 * i + 2, rdData[i]);
            tickN(2);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);

        // Reset during a write ACCESS and during a read ACCESS.
        t = cyc;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h80, 16'h1234);
        expEv(CA, t + 1, 16'h0);
        expLvl(t + 1, S_CSB, 16'd0);
        expLvl(t + 1, S_WEB, 16'd0);
        expLvl(t + 2, S_CSB, 16'd1);
        expLvl(t + 2, S_ADDR, 16'd0);
        expLvl(t + 2, S_BUSY, 16'd0);
        tickN(1);
        reset = 1'b1;
        tickN(1);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h80, 16'h0000);
        expEv(CA, t + 5, 16'h0);
        expLvl(t + 6, S_STROBE, 16'd0);
        expLvl(t + 6, S_ADDR, 16'd0);
        tickN(1);
        reset = 1'b1;
        tickN(1);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h80, 16'h0000);
        expEv(CA, t + 8, 16'h0);
        expEv(CR, t + 9, 16'h1234);
        tickN(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tickN(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
